// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared state encoding, MMIO addresses and default BRAM latency for the SLC-3 memory bridge.
package slc3_mem_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLD} mem_state_t;
  localparam logic [15:0] IO_HEX_ADDR = 16'hFFFF;
  localparam logic [15:0] IO_LED_ADDR = 16'hFFFE;
  localparam int RAM_LATENCY_DEF = 2;
endpackage

// File: rtl/slc3_mem_bridge_sync2.sv
// sync2: 16-bit two-flop synchroniser for the asynchronous board switches.
module sync2 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);
  logic [15:0] meta_q, sync_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/slc3_mem_bridge.sv
// slc3_mem_bridge: sequences SLC-3 memory requests onto a registered-output BRAM and MMIO (switches/hex at xFFFF).
// Define MMIO_LED_EN to map an LED register at xFFFE; otherwise that address is plain BRAM and led_o is 0.
module slc3_mem_bridge
  import slc3_mem_pkg::*;
#(
  parameter int RAM_LATENCY = RAM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        mem_ready,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o,
  output logic [15:0] led_o,
  output logic [15:0] bram_addr,
  output logic [15:0] bram_din,
  output logic        bram_ena,
  output logic        bram_we,
  input  logic [15:0] bram_dout
);
  if (RAM_LATENCY < 1 || RAM_LATENCY > 7) begin : g_bad_latency
    $error("RAM_LATENCY must be within 1..7");
  end
`ifdef MMIO_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif
  mem_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d, hex_q, hex_d, led_q, led_d;
  logic [15:0] addr_q, addr_d, din_q, din_d;
  logic        ena_q, ena_d, we_q, we_d;
  logic [15:0] sw_sync;
  logic        is_hex, is_led;
  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw_i),
    .q_o   (sw_sync)
  );
  assign is_hex = addr == IO_HEX_ADDR;
  assign is_led = LED_EN && addr == IO_LED_ADDR;
  // The BRAM port registers double as the request latch: they are loaded only on accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    hex_d   = hex_q;
    led_d   = led_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ena_d   = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      IDLE: if (mem_mem_ena) begin
        if (is_hex || is_led) begin
          state_d = DONE;
          hex_d   = (mem_wr_ena && is_hex) ? data_from_cpu : hex_q;
          led_d   = (mem_wr_ena && is_led) ? data_from_cpu : led_q;
          data_d  = mem_wr_ena ? data_q : (is_hex ? sw_sync : led_q);
        end else begin
          state_d = ISSUE;
          ena_d   = 1'b1;
          we_d    = mem_wr_ena;
          addr_d  = addr;
          din_d   = data_from_cpu;
        end
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        cnt_d   = 3'(RAM_LATENCY - 1);
      end
      WAIT: begin
        state_d = (cnt_q == 3'd0) ? DONE : WAIT;
        cnt_d   = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
        data_d  = (cnt_q == 3'd0) ? bram_dout : data_q;
      end
      DONE:    state_d = mem_mem_ena ? HOLD : IDLE;
      HOLD:    state_d = mem_mem_ena ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      hex_q   <= '0;
      led_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ena_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      hex_q   <= hex_d;
      led_q   <= led_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ena_q   <= ena_d;
      we_q    <= we_d;
    end
  assign data_to_cpu = data_q;
  assign mem_ready   = state_q == DONE;
  assign hex_o       = hex_q;
  assign led_o       = LED_EN ? led_q : 16'h0000;
  assign bram_addr   = addr_q;
  assign bram_din    = din_q;
  assign bram_ena    = ena_q;
  assign bram_we     = we_q;
endmodule

// File: tb/tb_slc3_mem_bridge.sv
// tb_slc3_mem_bridge: directed checks of BRAM read/write sequencing, MMIO, single issue and mid-access reset.
module tb_slc3_mem_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_mem_ena = 1'b0, mem_wr_ena = 1'b0;
  logic [15:0] addr = '0, data_from_cpu = '0, sw_i = '0;
  logic [15:0] data_to_cpu, hex_o, led_o, bram_addr, bram_din, bram_dout;
  logic        mem_ready, bram_ena, bram_we;
  logic [15:0] mem [256];
  logic [15:0] rd_q;
  int          pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  slc3_mem_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .mem_mem_ena   (mem_mem_ena),
    .mem_wr_ena    (mem_wr_ena),
    .addr          (addr),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu),
    .mem_ready     (mem_ready),
    .sw_i          (sw_i),
    .hex_o         (hex_o),
    .led_o         (led_o),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_ena      (bram_ena),
    .bram_we       (bram_we),
    .bram_dout     (bram_dout)
  );

  // Two-clock BRAM: address sampled on the enabled edge, dout valid one further edge later.
  always @(posedge clk) begin
    if (reset) mem[3] <= 16'h1234;
    else if (bram_ena) begin
      if (bram_we) mem[bram_addr[7:0]] <= bram_din;
      rd_q <= mem[bram_addr[7:0]];
    end
    bram_dout <= rd_q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the enable for n edges, scrambling the request after the first edge to prove it was latched.
  task automatic run(input logic [15:0] a, input logic wr, input logic [15:0] d, input int n,
                     output int rdy_at, output int rdy_n, output int ena_n, output int we_n);
    rdy_at = 0; rdy_n = 0; ena_n = 0; we_n = 0;
    addr = a; mem_wr_ena = wr; data_from_cpu = d; mem_mem_ena = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (mem_ready) begin
        rdy_n++;
        if (rdy_at == 0) rdy_at = k;
      end
      if (bram_ena) ena_n++;
      if (bram_we) we_n++;
      if (k == 1) begin
        addr = ~a; data_from_cpu = ~d; mem_wr_ena = ~wr;
      end
    end
    mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (data_to_cpu !== 16'h0) $display("FAIL reset_data got %h want 0000", data_to_cpu); else pass_cnt++;
    total_cnt++; if (mem_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", mem_ready); else pass_cnt++;
    total_cnt++; if (hex_o !== 16'h0 || led_o !== 16'h0) $display("FAIL reset_io got %h/%h want 0000/0000", hex_o, led_o); else pass_cnt++;
    total_cnt++; if ({bram_addr, bram_din, bram_ena, bram_we} !== 34'h0) $display("FAIL reset_bram got %h/%h/%b/%b want zeros", bram_addr, bram_din, bram_ena, bram_we); else pass_cnt++;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bram_read();
    addr = 16'h0003; mem_wr_ena = 1'b0; mem_mem_ena = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total_cnt++; if (bram_ena !== (k == 1)) $display("FAIL read_ena k=%0d got %b want %b", k, bram_ena, k == 1); else pass_cnt++;
      total_cnt++; if (mem_ready !== (k == 4)) $display("FAIL read_ready k=%0d got %b want %b", k, mem_ready, k == 4); else pass_cnt++;
      if (k == 1) begin
        total_cnt++; if (bram_addr !== 16'h0003 || bram_we !== 1'b0) $display("FAIL read_issue got %h/%b want 0003/0", bram_addr, bram_we); else pass_cnt++;
        addr = 16'h0077;
      end
      if (k == 3) begin
        total_cnt++; if (data_to_cpu !== 16'h0) $display("FAIL read_early got %h want 0000", data_to_cpu); else pass_cnt++;
      end
      if (k == 4) begin
        total_cnt++; if (data_to_cpu !== 16'h1234) $display("FAIL read_data got %h want 1234", data_to_cpu); else pass_cnt++;
      end
    end
    mem_mem_ena = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_bram_write();
    int rdy_at, rdy_n, ena_n, we_n;
    addr = 16'h0010; mem_wr_ena = 1'b1; data_from_cpu = 16'hBEEF; mem_mem_ena = 1'b1;
    tick();
    total_cnt++; if ({bram_ena, bram_we, bram_addr, bram_din} !== {2'b11, 16'h0010, 16'hBEEF}) $display("FAIL write_issue got %b%b %h %h want 11 0010 beef", bram_ena, bram_we, bram_addr, bram_din); else pass_cnt++;
    tick();
    total_cnt++; if (mem_ready !== 1'b1) $display("FAIL write_ready got %b want 1", mem_ready); else pass_cnt++;
    total_cnt++; if (data_to_cpu !== 16'h1234) $display("FAIL write_keeps_data got %h want 1234", data_to_cpu); else pass_cnt++;
    mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    tick();
    tick();
    run(16'h0010, 1'b0, 16'h0, 5, rdy_at, rdy_n, ena_n, we_n);
    total_cnt++; if (data_to_cpu !== 16'hBEEF || rdy_at != 4) $display("FAIL write_readback got %h@%0d want beef@4", data_to_cpu, rdy_at); else pass_cnt++;
  endtask

  task automatic test_io();
    int rdy_at, rdy_n, ena_n, we_n;
    sw_i = 16'hA5A5;
    tick(); tick(); tick();
    run(16'hFFFF, 1'b0, 16'h0, 3, rdy_at, rdy_n, ena_n, we_n);
    total_cnt++; if (data_to_cpu !== 16'hA5A5) $display("FAIL io_read_data got %h want a5a5", data_to_cpu); else pass_cnt++;
    total_cnt++; if (rdy_at != 1 || ena_n != 0) $display("FAIL io_read_timing got ready@%0d ena=%0d want ready@1 ena=0", rdy_at, ena_n); else pass_cnt++;
    run(16'hFFFF, 1'b1, 16'h00C3, 3, rdy_at, rdy_n, ena_n, we_n);
    total_cnt++; if (hex_o !== 16'h00C3) $display("FAIL io_write_hex got %h want 00c3", hex_o); else pass_cnt++;
    total_cnt++; if (rdy_at != 1 || ena_n != 0 || data_to_cpu !== 16'hA5A5) $display("FAIL io_write_side got ready@%0d ena=%0d data=%h want 1/0/a5a5", rdy_at, ena_n, data_to_cpu); else pass_cnt++;
    run(16'hFFFD, 1'b1, 16'h7777, 3, rdy_at, rdy_n, ena_n, we_n);
    total_cnt++; if (hex_o !== 16'h00C3 || ena_n != 1 || rdy_at != 2) $display("FAIL io_near_addr got hex=%h ena=%0d ready@%0d want 00c3/1/2", hex_o, ena_n, rdy_at); else pass_cnt++;
  endtask

  task automatic test_single_issue();
    int rdy_at, rdy_n, ena_n, we_n;
    run(16'h0020, 1'b0, 16'h0, 10, rdy_at, rdy_n, ena_n, we_n);
    total_cnt++; if (ena_n != 1 || rdy_n != 1) $display("FAIL single_issue got ena=%0d ready=%0d want 1/1", ena_n, rdy_n); else pass_cnt++;
    total_cnt++; if (rdy_at != 4) $display("FAIL single_latency got %0d want 4", rdy_at); else pass_cnt++;
  endtask

  task automatic test_led();
    int rdy_at, rdy_n, ena_n, we_n;
    run(16'hFFFE, 1'b1, 16'h0F0F, 3, rdy_at, rdy_n, ena_n, we_n);
`ifdef MMIO_LED_EN
    total_cnt++; if (led_o !== 16'h0F0F || ena_n != 0 || rdy_at != 1) $display("FAIL led_write got led=%h ena=%0d ready@%0d want 0f0f/0/1", led_o, ena_n, rdy_at); else pass_cnt++;
    run(16'hFFFE, 1'b0, 16'h0, 3, rdy_at, rdy_n, ena_n, we_n);
    total_cnt++; if (data_to_cpu !== 16'h0F0F || rdy_at != 1) $display("FAIL led_read got %h@%0d want 0f0f@1", data_to_cpu, rdy_at); else pass_cnt++;
`else
    total_cnt++; if (led_o !== 16'h0 || we_n != 1 || rdy_at != 2) $display("FAIL led_as_bram got led=%h we=%0d ready@%0d want 0000/1/2", led_o, we_n, rdy_at); else pass_cnt++;
`endif
  endtask

  task automatic test_mid_reset();
    int rdy_at, rdy_n, ena_n, we_n;
    run(16'h0003, 1'b0, 16'h0, 5, rdy_at, rdy_n, ena_n, we_n);
    addr = 16'h0003; mem_wr_ena = 1'b0; mem_mem_ena = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total_cnt++; if (data_to_cpu !== 16'h0 || hex_o !== 16'h0) $display("FAIL midreset_regs got %h/%h want 0000/0000", data_to_cpu, hex_o); else pass_cnt++;
    total_cnt++; if (mem_ready !== 1'b0 || bram_ena !== 1'b0 || bram_addr !== 16'h0) $display("FAIL midreset_ctl got %b/%b/%h want 0/0/0000", mem_ready, bram_ena, bram_addr); else pass_cnt++;
    mem_mem_ena = 1'b0;
    tick();
    reset = 1'b0;
    rdy_n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_ready || bram_ena) rdy_n++;
    end
    total_cnt++; if (rdy_n != 0) $display("FAIL midreset_quiet got %0d activity cycles want 0", rdy_n); else pass_cnt++;
    run(16'h0003, 1'b0, 16'h0, 5, rdy_at, rdy_n, ena_n, we_n);
    total_cnt++; if (data_to_cpu !== 16'h1234 || rdy_at != 4) $display("FAIL midreset_recover got %h@%0d want 1234@4", data_to_cpu, rdy_at); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bram_read();
    test_bram_write();
    test_io();
    test_single_issue();
    test_led();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
